// File: rtl/calc_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// calc_pkg: shared encodings and field widths for the calculator sequencer.
// Rev 1.0
// ------------------------------------------------------------------------
package calc_pkg;

    localparam int MODE_W    = 3;
    localparam int OPERAND_W = 32;
    localparam int N_W       = 32;
    localparam int CMD_W     = MODE_W + OPERAND_W + N_W;

    localparam logic [31:0] CALC_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_RUN     = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4,
        S_ABORT   = 3'd5
    } calc_state_e;

    typedef struct packed {
        logic [MODE_W-1:0]    mode;
        logic [OPERAND_W-1:0] operand;
        logic [N_W-1:0]       n;
    } calc_cmd_t;

endpackage
`default_nettype wire

// File: rtl/calc_cmd_fifo.sv
`default_nettype none
// ------------------------------------------------------------------------
// calc_cmd_fifo: small synchronous FIFO, extra pointer MSB separates full/empty.
// Rev 1.0
// ------------------------------------------------------------------------
module calc_cmd_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 67
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage needs no reset: empty flag masks stale entries.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/calc_cmd_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------------
// calc_cmd_sequencer: queues commands, runs the FP calculator, returns results.
// Define CALC_SEQ_PERF_EN for rsp_cycles / perf_aborts.   Rev 1.0
// ------------------------------------------------------------------------
module calc_cmd_sequencer
    import calc_pkg::*;
#(
    parameter logic [8:0] IDLE_STATE     = 9'd0,
    parameter int         FIFO_DEPTH     = 4,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [MODE_W-1:0]    cmd_mode,
    input  logic [OPERAND_W-1:0] cmd_operand,
    input  logic [N_W-1:0]       cmd_n,
    output logic                 calc_start,
    output logic                 calc_reset,
    output logic [MODE_W-1:0]    calc_mode,
    output logic [OPERAND_W-1:0] calc_input,
    output logic [N_W-1:0]       calc_n,
    input  logic [8:0]           calc_state,
    input  logic [31:0]          calc_acc,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic [MODE_W-1:0]    rsp_mode,
    output logic                 rsp_timeout,
`ifdef CALC_SEQ_PERF_EN
    output logic [15:0]          rsp_cycles,
    output logic [7:0]           perf_aborts,
`endif
    output logic                 busy
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    calc_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 calc_start_q;
    logic                 calc_reset_q;
    logic [MODE_W-1:0]    calc_mode_q;
    logic [OPERAND_W-1:0] calc_input_q;
    logic [N_W-1:0]       calc_n_q;
    logic                 rsp_valid_q;
    logic [31:0]          rsp_data_q;
    logic [MODE_W-1:0]    rsp_mode_q;
    logic                 rsp_timeout_q;

    calc_cmd_t head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_pop;
    logic      calc_idle;

    // Gated by reset so every output reads 0 while reset is held.
    assign cmd_ready = !fifo_full && !reset;
    assign fifo_pop  = (state_q == S_IDLE) && !fifo_empty;
    assign calc_idle = (calc_state == IDLE_STATE);

    calc_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (cmd_valid && cmd_ready),
        .data_i  ({cmd_mode, cmd_operand, cmd_n}),
        .pop_i   (fifo_pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            calc_start_q  <= 1'b0;
            calc_reset_q  <= 1'b0;
            calc_mode_q   <= '0;
            calc_input_q  <= '0;
            calc_n_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_mode_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        calc_mode_q  <= head.mode;
                        calc_input_q <= head.operand;
                        calc_n_q     <= head.n;
                        cnt_q        <= '0;
                        calc_start_q <= 1'b1;
                        state_q      <= S_LAUNCH;
                    end
                end
                S_LAUNCH, S_RUN: begin
                    // Counter holds at its limit so it can never wrap.
                    if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
                    if (state_q == S_LAUNCH && !calc_idle) begin
                        calc_start_q <= 1'b0;
                        state_q      <= S_RUN;
                    end else if (state_q == S_RUN && calc_idle) begin
                        state_q <= S_CAPTURE;
                    end else if (cnt_q == CNT_MAX) begin
                        calc_start_q <= 1'b0;
                        calc_reset_q <= 1'b1;
                        state_q      <= S_ABORT;
                    end
                end
                S_CAPTURE: begin
                    rsp_data_q    <= calc_acc;
                    rsp_mode_q    <= calc_mode_q;
                    rsp_timeout_q <= 1'b0;
                    rsp_valid_q   <= 1'b1;
                    state_q       <= S_RESP;
                end
                S_ABORT: begin
                    calc_reset_q  <= 1'b0;
                    rsp_data_q    <= CALC_QNAN;
                    rsp_mode_q    <= calc_mode_q;
                    rsp_timeout_q <= 1'b1;
                    rsp_valid_q   <= 1'b1;
                    state_q       <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign calc_start  = calc_start_q;
    assign calc_reset  = calc_reset_q;
    assign calc_mode   = calc_mode_q;
    assign calc_input  = calc_input_q;
    assign calc_n      = calc_n_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_mode    = rsp_mode_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = !fifo_empty || (state_q != S_IDLE);

`ifdef CALC_SEQ_PERF_EN
    logic [15:0] cyc_q;
    logic [15:0] rsp_cycles_q;
    logic [7:0]  aborts_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q        <= '0;
            rsp_cycles_q <= '0;
            aborts_q     <= '0;
        end else begin
            if (fifo_pop) begin
                cyc_q <= '0;
            end else if ((state_q == S_LAUNCH || state_q == S_RUN) && cyc_q != 16'hFFFF) begin
                cyc_q <= cyc_q + 1'b1;
            end
            if (state_q == S_CAPTURE || state_q == S_ABORT) rsp_cycles_q <= cyc_q;
            if (state_q == S_ABORT && aborts_q != 8'hFF) aborts_q <= aborts_q + 1'b1;
        end
    end

    assign rsp_cycles  = rsp_cycles_q;
    assign perf_aborts = aborts_q;
`endif

endmodule
`default_nettype wire
